// File: rtl/sram_session_arbiter.sv
// SRAM bus owner: VGA reader by default, UART load sessions with inactivity timeout,
// round-robin compute clients. Optional grant watchdog enabled by SRAM_GRANT_WATCHDOG_EN.
module sram_session_arbiter #(
    parameter int NUM_CLIENTS    = 2,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int TIMER_W        = 26,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                          CLOCK_50_I,
    input  logic                          resetn,
    input  logic                          uart_rx_i,
    input  logic                          start_load,
    output logic                          load_initialize,
    output logic                          load_enable,
    input  logic [ADDR_W-1:0]             load_address,
    input  logic [DATA_W-1:0]             load_write_data,
    input  logic                          load_we_n,
    input  logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS-1:0]        done,
    output logic [NUM_CLIENTS-1:0]        grant,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] client_address,
    input  logic [NUM_CLIENTS*DATA_W-1:0] client_write_data,
    input  logic [NUM_CLIENTS-1:0]        client_we_n,
    input  logic [ADDR_W-1:0]             vga_address,
    output logic                          vga_enable,
    output logic [ADDR_W-1:0]             SRAM_address,
    output logic [DATA_W-1:0]             SRAM_write_data,
    output logic                          SRAM_we_n,
    output logic [2:0]                    state_o,
    output logic                          watchdog_error
);

    localparam int                 PTR_W        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0]   LAST_CLIENT  = PTR_W'(NUM_CLIENTS - 1);

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_ENABLE_UART_RX = 3'd1,
        S_WAIT_UART_RX   = 3'd2,
        S_GRANT          = 3'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]       gidx_q, gidx_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       pick_idx, cand;
    logic                   pick_found;
    logic                   vga_enable_q, vga_enable_d;
    logic                   load_init_q, load_init_d;
    logic                   load_en_q, load_en_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   timer_clr;
    logic                   release_grant;
`ifdef SRAM_GRANT_WATCHDOG_EN
    logic                   wd_err_q, wd_err_d;
    logic                   wd_trip;
`endif

    // First asserted request at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            cand = PTR_W'((32'(ptr_q) + i) % NUM_CLIENTS);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        ptr_d         = ptr_q;
        vga_enable_d  = vga_enable_q;
        load_init_d   = 1'b0;
        load_en_d     = 1'b0;
        release_grant = 1'b0;
`ifdef SRAM_GRANT_WATCHDOG_EN
        wd_err_d      = wd_err_q;
        wd_trip       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                vga_enable_d = 1'b1;
                if (!uart_rx_i || start_load) begin
                    load_init_d  = 1'b1;
                    vga_enable_d = 1'b0;
                    state_d      = S_ENABLE_UART_RX;
                end else if (pick_found) begin
                    grant_d      = NUM_CLIENTS'(1) << pick_idx;
                    gidx_d       = pick_idx;
                    vga_enable_d = 1'b0;
                    state_d      = S_GRANT;
                end
            end
            S_ENABLE_UART_RX: begin
                load_en_d = 1'b1;
                state_d   = S_WAIT_UART_RX;
            end
            S_WAIT_UART_RX: begin
                // An empty load (address still 0) keeps the session open forever.
                if (timer_q == TIMEOUT_LAST && load_address != '0) begin
                    load_init_d  = 1'b1;
                    vga_enable_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_GRANT: begin
                release_grant = done[gidx_q];
`ifdef SRAM_GRANT_WATCHDOG_EN
                wd_trip = (timer_q == TIMEOUT_LAST);
                if (wd_trip) begin
                    wd_err_d      = 1'b1;
                    release_grant = 1'b1;
                end
`endif
                if (release_grant) begin
                    grant_d      = '0;
                    ptr_d        = (gidx_q == LAST_CLIENT) ? '0 : gidx_q + 1'b1;
                    vga_enable_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                grant_d      = '0;
                vga_enable_d = 1'b1;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_comb begin
        timer_clr = load_init_q | ~load_we_n;
`ifdef SRAM_GRANT_WATCHDOG_EN
        if (state_q == S_GRANT) begin
            timer_clr = ~client_we_n[gidx_q];
        end
        if (state_q == S_IDLE && state_d == S_GRANT) begin
            timer_clr = 1'b1;
        end
`endif
        if (timer_clr) begin
            timer_d = '0;
        end else if (&timer_q) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            ptr_q        <= '0;
            vga_enable_q <= 1'b1;
            load_init_q  <= 1'b0;
            load_en_q    <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            ptr_q        <= ptr_d;
            vga_enable_q <= vga_enable_d;
            load_init_q  <= load_init_d;
            load_en_q    <= load_en_d;
            timer_q      <= timer_d;
        end
    end

`ifdef SRAM_GRANT_WATCHDOG_EN
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            wd_err_q <= 1'b0;
        end else begin
            wd_err_q <= wd_err_d;
        end
    end
    assign watchdog_error = wd_err_q;
`else
    assign watchdog_error = 1'b0;
`endif

    always_comb begin
        SRAM_address    = vga_address;
        SRAM_we_n       = 1'b1;
        SRAM_write_data = client_write_data[gidx_q*DATA_W +: DATA_W];
        case (state_q)
            S_ENABLE_UART_RX, S_WAIT_UART_RX: begin
                SRAM_address    = load_address;
                SRAM_we_n       = load_we_n;
                SRAM_write_data = load_write_data;
            end
            S_GRANT: begin
                SRAM_address = client_address[gidx_q*ADDR_W +: ADDR_W];
                SRAM_we_n    = client_we_n[gidx_q];
            end
            default: ;
        endcase
    end

    assign load_initialize = load_init_q;
    assign load_enable     = load_en_q;
    assign grant           = grant_q;
    assign vga_enable      = vga_enable_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_sram_session_arbiter.sv
// Directed bench for sram_session_arbiter: per-cycle vector table plus multi-cycle
// sequences for UART timeout, round-robin rotation and the grant watchdog.
module tb_sram_session_arbiter;

    localparam int NC = 3;
    localparam int AW = 18;
    localparam int DW = 16;

    localparam logic [AW-1:0] VGA = 18'h12345;
    localparam logic [AW-1:0] C0  = 18'h01000;
    localparam logic [AW-1:0] C1  = 18'h2A000;
    localparam logic [AW-1:0] C2  = 18'h03000;

    logic             clk;
    logic             resetn;
    logic             uart_rx_i;
    logic             start_load;
    logic             load_initialize;
    logic             load_enable;
    logic [AW-1:0]    load_address;
    logic [DW-1:0]    load_write_data;
    logic             load_we_n;
    logic [NC-1:0]    req;
    logic [NC-1:0]    done;
    logic [NC-1:0]    grant;
    logic [NC*AW-1:0] client_address;
    logic [NC*DW-1:0] client_write_data;
    logic [NC-1:0]    client_we_n;
    logic [AW-1:0]    vga_address;
    logic             vga_enable;
    logic [AW-1:0]    SRAM_address;
    logic [DW-1:0]    SRAM_write_data;
    logic             SRAM_we_n;
    logic [2:0]       state_o;
    logic             watchdog_error;

    int errors = 0;
    int checks = 0;
    int n;

    sram_session_arbiter #(
        .NUM_CLIENTS   (NC),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMER_W       (26),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLOCK_50_I       (clk),
        .resetn           (resetn),
        .uart_rx_i        (uart_rx_i),
        .start_load       (start_load),
        .load_initialize  (load_initialize),
        .load_enable      (load_enable),
        .load_address     (load_address),
        .load_write_data  (load_write_data),
        .load_we_n        (load_we_n),
        .req              (req),
        .done             (done),
        .grant            (grant),
        .client_address   (client_address),
        .client_write_data(client_write_data),
        .client_we_n      (client_we_n),
        .vga_address      (vga_address),
        .vga_enable       (vga_enable),
        .SRAM_address     (SRAM_address),
        .SRAM_write_data  (SRAM_write_data),
        .SRAM_we_n        (SRAM_we_n),
        .state_o          (state_o),
        .watchdog_error   (watchdog_error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic          rstn;
        logic          uart;
        logic          start;
        logic [NC-1:0] rq;
        logic [NC-1:0] dn;
        logic [AW-1:0] la;
        logic          lwe;
        logic          e_li;
        logic          e_le;
        logic [NC-1:0] e_gnt;
        logic          e_vga;
        logic [2:0]    e_st;
        logic [AW-1:0] e_addr;
        logic          e_we;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        uart_rx_i    = 1'b1;
        start_load   = 1'b0;
        req          = '0;
        done         = '0;
        load_address = 18'h00100;
        load_we_n    = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        //            rstn uart start rq      dn      la        lwe | li   le   gnt     vga  st    addr      we
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 18'h00100, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'd0, VGA,      1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 18'h00100, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'd1, 18'h00100, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 18'h00100, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 3'd2, 18'h00100, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 18'h00200, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'd2, 18'h00200, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b111, 3'b000, 18'h00200, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'd2, 18'h00200, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 18'h00200, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'd0, VGA,      1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 3'b001, 3'b000, 18'h00200, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'd1, 18'h00200, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b001, 3'b000, 18'h00200, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 3'd2, 18'h00200, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 18'h00200, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'd0, VGA,      1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'b010, 3'b000, 18'h00200, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 3'd3, C1,       1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b001, 18'h00200, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 3'd3, C1,       1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b010, 18'h00200, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'd0, VGA,      1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 3'b011, 3'b000, 18'h00200, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 3'd3, C0,       1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b001, 18'h00200, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'd0, VGA,      1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 3'b101, 3'b000, 18'h00200, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 3'd3, C2,       1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b100, 18'h00200, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'd0, VGA,      1'b1};

        vga_address       = VGA;
        client_address    = {C2, C1, C0};
        client_write_data = {16'hA002, 16'hA001, 16'hA000};
        client_we_n       = 3'b101;
        load_write_data   = 16'h5555;
        idle_inputs();
        resetn = 1'b0;
        step();
        step();
        chk("reset.state", 32'(state_o), 32'd0);
        chk("reset.vga_enable", 32'(vga_enable), 32'd1);
        chk("reset.grant", 32'(grant), 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            resetn       = vecs[i].rstn;
            uart_rx_i    = vecs[i].uart;
            start_load   = vecs[i].start;
            req          = vecs[i].rq;
            done         = vecs[i].dn;
            load_address = vecs[i].la;
            load_we_n    = vecs[i].lwe;
            step();
            chk($sformatf("v%0d.load_initialize", i), 32'(load_initialize), 32'(vecs[i].e_li));
            chk($sformatf("v%0d.load_enable", i), 32'(load_enable), 32'(vecs[i].e_le));
            chk($sformatf("v%0d.grant", i), 32'(grant), 32'(vecs[i].e_gnt));
            chk($sformatf("v%0d.vga_enable", i), 32'(vga_enable), 32'(vecs[i].e_vga));
            chk($sformatf("v%0d.state", i), 32'(state_o), 32'(vecs[i].e_st));
            chk($sformatf("v%0d.SRAM_address", i), 32'(SRAM_address), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d.SRAM_we_n", i), 32'(SRAM_we_n), 32'(vecs[i].e_we));
            chk($sformatf("v%0d.watchdog_error", i), 32'(watchdog_error), 32'd0);
        end

        // UART inactivity timeout: 100 cycles in S_WAIT_UART_RX with a non-zero address.
        do_reset();
        uart_rx_i = 1'b0;
        step();
        uart_rx_i = 1'b1;
        chk("to.start_state", 32'(state_o), 32'd1);
        for (n = 1; n <= 300; n++) begin
            step();
            if (n == 1) chk("to.uart_write_data", 32'(SRAM_write_data), 32'h5555);
            if (state_o == 3'd0) break;
        end
        chk("to.cycles_to_idle", 32'(n), 32'd101);
        chk("to.load_initialize", 32'(load_initialize), 32'd1);
        chk("to.vga_enable", 32'(vga_enable), 32'd1);

        // No timeout while load_address stays zero.
        do_reset();
        load_address = '0;
        start_load   = 1'b1;
        step();
        start_load = 1'b0;
        repeat (1000) step();
        chk("noto.state", 32'(state_o), 32'd2);
        chk("noto.vga_enable", 32'(vga_enable), 32'd0);

        // Round-robin rotation with req held, done 5 cycles after each grant.
        begin
            logic [NC-1:0] exp_g [4];
            exp_g[0] = 3'b001;
            exp_g[1] = 3'b010;
            exp_g[2] = 3'b100;
            exp_g[3] = 3'b001;
            do_reset();
            req = 3'b111;
            for (int g = 0; g < 4; g++) begin
                step();
                chk($sformatf("rr%0d.grant", g), 32'(grant), 32'(exp_g[g]));
                chk($sformatf("rr%0d.write_data", g), 32'(SRAM_write_data),
                    (g == 1) ? 32'hA001 : ((g == 2) ? 32'hA002 : 32'hA000));
                repeat (4) step();
                chk($sformatf("rr%0d.grant_hold", g), 32'(grant), 32'(exp_g[g]));
                done = exp_g[g];
                step();
                done = '0;
                chk($sformatf("rr%0d.idle_state", g), 32'(state_o), 32'd0);
                chk($sformatf("rr%0d.idle_grant", g), 32'(grant), 32'd0);
                chk($sformatf("rr%0d.idle_vga", g), 32'(vga_enable), 32'd1);
            end
            req = '0;
        end

`ifdef SRAM_GRANT_WATCHDOG_EN
        // Client 0 never releases; the watchdog revokes after 100 cycles.
        do_reset();
        req = 3'b001;
        step();
        req = '0;
        chk("wd.grant", 32'(grant), 32'b001);
        for (n = 1; n <= 300; n++) begin
            step();
            if (grant == '0) break;
        end
        chk("wd.cycles_to_revoke", 32'(n), 32'd100);
        chk("wd.error_set", 32'(watchdog_error), 32'd1);
        chk("wd.state", 32'(state_o), 32'd0);
        req = 3'b010;
        step();
        req = '0;
        chk("wd.next_grant", 32'(grant), 32'b010);
        done = 3'b010;
        step();
        done = '0;
        chk("wd.error_sticky", 32'(watchdog_error), 32'd1);
        chk("wd.released", 32'(grant), 32'd0);
`else
        // Without the watchdog a silent client keeps the bus indefinitely.
        do_reset();
        req = 3'b001;
        step();
        req = '0;
        repeat (150) step();
        chk("nowd.grant_held", 32'(grant), 32'b001);
        chk("nowd.error", 32'(watchdog_error), 32'd0);
        done = 3'b001;
        step();
        done = '0;
        chk("nowd.released", 32'(grant), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
